// File: rtl/fcp_inj_pkg.sv
// Shared types, header field layout and credit arithmetic for the FCP credit injector.
package fcp_inj_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_SEND = 2'd2
   } inj_state_t;

   localparam int SEQ_LSB = 0;
   localparam int SEQ_W   = 32;
   localparam int VC_LSB  = 32;
   localparam int VC_W    = 16;

   // Credit exists when (fccl - fccr) mod 2^width, read as signed, is strictly positive.
   function automatic logic credit_avail(input logic [63:0] fccl,
                                         input logic [63:0] fccr,
                                         input int          width);
      logic [63:0] diff;
      diff = fccl - fccr;
      if (width < 64) diff = diff & ((64'd1 << width) - 64'd1);
      return (diff != 64'd0) && (((diff >> (width - 1)) & 64'd1) == 64'd0);
   endfunction

endpackage

// File: rtl/fcp_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module fcp_rr_arbiter #(
   parameter  int IDX_W = 4,
   localparam int N     = 2**IDX_W
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      cand        = ptr;
      grant_idx   = ptr;
      grant_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fcp_credit_injector.sv
// Multi-VC credit-gated AXI-Stream packet injector with round-robin VC selection.
// Optional per-VC packet statistics are enabled with FCP_INJ_VC_STATS_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | injection disabled, no traffic
//  ARB     | searching for an eligible VC from rr_ptr (one cycle minimum)
//  SEND    | streaming BEATS beats of the packet for cur_vc
module fcp_credit_injector
   import fcp_inj_pkg::*;
#(
   parameter  int VC_INDEX_WIDTH = 4,
   parameter  int DATA_WIDTH     = 64,
   parameter  int PKT_LEN_BYTES  = 64,
   parameter  int CREDIT_WIDTH   = 32,
   parameter  int INIT_CREDITS   = 8,
   parameter  int STAT_WIDTH     = 32,
   localparam int VC_COUNT       = 2**VC_INDEX_WIDTH,
   localparam int KEEP_W         = DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [VC_COUNT-1:0]       vc_mask,
   input  logic                      fcp_valid,
   input  logic [VC_INDEX_WIDTH-1:0] fcp_vc,
   input  logic [CREDIT_WIDTH-1:0]   fcp_fccl,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [KEEP_W-1:0]         m_axis_tkeep,
   output logic [63:0]               m_axis_tx_pkt_count,
   output logic                      injector_active
`ifdef FCP_INJ_VC_STATS_EN
   ,
   input  logic [VC_INDEX_WIDTH-1:0] stat_vc_idx,
   output logic [STAT_WIDTH-1:0]     stat_vc_tx_count
`endif
);

   localparam int BEATS  = PKT_LEN_BYTES / KEEP_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   if (DATA_WIDTH < 64 || (DATA_WIDTH % 8) != 0 || BEATS < 1 ||
       (PKT_LEN_BYTES % KEEP_W) != 0 || STAT_WIDTH < 1) begin : g_bad_params
      $error("fcp_credit_injector: illegal parameter combination");
   end

   inj_state_t                state, state_nxt;
   logic [CREDIT_WIDTH-1:0]   fccl [VC_COUNT];
   logic [CREDIT_WIDTH-1:0]   fccr [VC_COUNT];
   logic [VC_INDEX_WIDTH-1:0] cur_vc;
   logic [VC_INDEX_WIDTH-1:0] rr_ptr;
   logic [VC_INDEX_WIDTH-1:0] grant_idx;
   logic                      grant_valid;
   logic [BEAT_W-1:0]         beat_cnt;
   logic [VC_COUNT-1:0]       req;
   logic                      beat_fire;
   logic                      pkt_done;
   logic                      start_pkt;

   always_comb begin
      req = '0;
      for (int v = 0; v < VC_COUNT; v++) begin
         req[v] = enable && vc_mask[v] &&
                  credit_avail(64'(fccl[v]), 64'(fccr[v]), CREDIT_WIDTH);
      end
   end

   fcp_rr_arbiter #(.IDX_W(VC_INDEX_WIDTH)) u_arb (
      .req         (req),
      .ptr         (rr_ptr),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (enable) state_nxt = ST_ARB;
         ST_ARB: begin
            if (!enable)          state_nxt = ST_IDLE;
            else if (grant_valid) state_nxt = ST_SEND;
         end
         ST_SEND: if (pkt_done) state_nxt = enable ? ST_ARB : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign m_axis_tvalid   = (state == ST_SEND);
   assign m_axis_tlast    = m_axis_tvalid && (beat_cnt == LAST_BEAT);
   assign m_axis_tkeep    = {KEEP_W{m_axis_tvalid}};
   assign injector_active = (state != ST_IDLE);
   assign beat_fire       = m_axis_tvalid && m_axis_tready;
   assign pkt_done        = beat_fire && m_axis_tlast;
   assign start_pkt       = (state == ST_ARB) && (state_nxt == ST_SEND);

   // Payload depends only on registers that are frozen while a beat is pending.
   always_comb begin
      m_axis_tdata = '0;
      if (m_axis_tvalid) begin
         if (beat_cnt == '0) begin
            m_axis_tdata[SEQ_LSB +: SEQ_W] = 32'(fccr[cur_vc]);
            m_axis_tdata[VC_LSB  +: VC_W]  = 16'(cur_vc);
         end else begin
            m_axis_tdata[15:0] = 16'(beat_cnt);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VC_COUNT; v++) fccl[v] <= CREDIT_WIDTH'(INIT_CREDITS);
      end else if (fcp_valid) begin
         fccl[fcp_vc] <= fcp_fccl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_vc              <= '0;
         rr_ptr              <= '0;
         beat_cnt            <= '0;
         m_axis_tx_pkt_count <= '0;
         for (int v = 0; v < VC_COUNT; v++) fccr[v] <= '0;
      end else begin
         if (start_pkt) begin
            cur_vc   <= grant_idx;
            beat_cnt <= '0;
         end else if (beat_fire) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
         if (pkt_done) begin
            fccr[cur_vc]        <= fccr[cur_vc] + CREDIT_WIDTH'(1);
            m_axis_tx_pkt_count <= m_axis_tx_pkt_count + 64'd1;
            rr_ptr              <= cur_vc + VC_INDEX_WIDTH'(1);
         end
      end
   end

`ifdef FCP_INJ_VC_STATS_EN
   logic [STAT_WIDTH-1:0] stat_cnt [VC_COUNT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VC_COUNT; v++) stat_cnt[v] <= '0;
      end else if (pkt_done) begin
         stat_cnt[cur_vc] <= stat_cnt[cur_vc] + STAT_WIDTH'(1);
      end
   end

   assign stat_vc_tx_count = stat_cnt[stat_vc_idx];
`endif

endmodule

// File: tb/tb_fcp_credit_injector.sv
// Scoreboard bench for fcp_credit_injector: a packet-level credit model predicts beats, a monitor checks them.
module tb_fcp_credit_injector;

   localparam int VIW   = 2;
   localparam int NVC   = 4;
   localparam int DW    = 64;
   localparam int PLB   = 64;
   localparam int CW    = 4;
   localparam int INIT  = 2;
   localparam int BEATS = 8;
   localparam int CMOD  = 16;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           enable    = 1'b0;
   logic [NVC-1:0] vc_mask   = '0;
   logic           fcp_valid = 1'b0;
   logic [VIW-1:0] fcp_vc    = '0;
   logic [CW-1:0]  fcp_fccl  = '0;
   logic [DW-1:0]  tdata;
   logic           tvalid;
   logic           tready    = 1'b1;
   logic           tlast;
   logic [DW/8-1:0] tkeep;
   logic [63:0]    pkt_count;
   logic           active;

   always #5 clk = ~clk;

   fcp_credit_injector #(
      .VC_INDEX_WIDTH(VIW), .DATA_WIDTH(DW), .PKT_LEN_BYTES(PLB),
      .CREDIT_WIDTH(CW), .INIT_CREDITS(INIT), .STAT_WIDTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .vc_mask(vc_mask),
      .fcp_valid(fcp_valid), .fcp_vc(fcp_vc), .fcp_fccl(fcp_fccl),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .m_axis_tkeep(tkeep),
      .m_axis_tx_pkt_count(pkt_count), .injector_active(active)
   );

   typedef struct {
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    m_fccl[NVC];
   int    m_fccr[NVC];
   int    m_rr;
   int    m_pkts;
   int    beats_acc = 0;
   bit    rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int wrapc(input int x);
      return ((x % CMOD) + CMOD) % CMOD;
   endfunction

   function automatic bit m_credit(input int v);
      int d;
      d = wrapc(m_fccl[v] - m_fccr[v]);
      return (d != 0) && (d < CMOD / 2);
   endfunction

   task automatic model_reset();
      for (int v = 0; v < NVC; v++) begin
         m_fccl[v] = INIT;
         m_fccr[v] = 0;
      end
      m_rr   = 0;
      m_pkts = 0;
   endtask

   // Predict the packets the injector owes given current credits, mask and pointer.
   task automatic run_model(input int max_pkts);
      int    sent;
      int    g;
      int    v;
      beat_t b;
      sent = 0;
      while (sent < max_pkts) begin
         g = -1;
         for (int i = 0; i < NVC; i++) begin
            v = (m_rr + i) % NVC;
            if (g < 0 && vc_mask[v] && m_credit(v)) g = v;
         end
         if (g < 0) break;
         for (int k = 0; k < BEATS; k++) begin
            b.data = (k == 0) ? {16'd0, 16'(g), 32'(m_fccr[g])} : 64'(k);
            b.last = (k == BEATS - 1);
            exp_q.push_back(b);
         end
         m_fccr[g] = wrapc(m_fccr[g] + 1);
         m_rr      = (g + 1) % NVC;
         m_pkts++;
         sent++;
      end
   endtask

   task automatic fcp(input int v, input int val);
      @(posedge clk); #1;
      fcp_valid = 1'b1;
      fcp_vc    = VIW'(v);
      fcp_fccl  = CW'(wrapc(val));
      m_fccl[v] = wrapc(val);
      @(posedge clk); #1;
      fcp_valid = 1'b0;
   endtask

   task automatic set_enable(input bit e);
      @(posedge clk); #1;
      enable = e;
   endtask

   task automatic quiesce(input string name);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 4000) begin
         @(posedge clk);
         cyc++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk); #1;
      tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Monitor: compares accepted beats against the scoreboard and checks AXI hold rules.
   initial begin
      logic        prev_v, prev_r, prev_l;
      logic [63:0] prev_d;
      beat_t       e;
      prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0;
            continue;
         end
         if (prev_v && !prev_r) begin
            check("stall_valid", 64'(tvalid), 64'd1);
            check("stall_data", tdata, prev_d);
            check("stall_last", 64'(tlast), 64'(prev_l));
         end
         if (tvalid) check("tkeep", 64'(tkeep), 64'hFF);
         if (tvalid && tready) begin
            beats_acc++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", tdata, tlast);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", tdata, e.data);
               check("beat_last", 64'(tlast), 64'(e.last));
            end
         end
         prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int start;
      int cyc;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tlast", 64'(tlast), 64'd0);
      check("rst_tkeep", 64'(tkeep), 64'd0);
      check("rst_tdata", tdata, 64'd0);
      check("rst_count", pkt_count, 64'd0);
      check("rst_active", 64'(active), 64'd0);
      rst_n = 1'b1;

      // Initial credits drain round-robin, then stall in ARB.
      @(posedge clk); #1;
      vc_mask = 4'hF;
      enable  = 1'b1;
      run_model(1000);
      quiesce("phase_a");
      check("a_count", pkt_count, 64'd8);
      check("a_active", 64'(active), 64'd1);
      check("a_tvalid", 64'(tvalid), 64'd0);

      fcp(2, 5);
      run_model(1000);
      quiesce("phase_b");
      check("b_count", pkt_count, 64'd11);

      // Drop enable during beat 1: packet completes, nothing further.
      set_enable(1'b0);
      repeat (3) @(posedge clk);
      fcp(3, m_fccr[3] + 3);
      fcp(0, m_fccr[0] + 2);
      set_enable(1'b1);
      start = beats_acc;
      run_model(1);
      cyc = 0;
      while (beats_acc <= start && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("edrop_wait", 64'(beats_acc > start), 64'd1);
      enable = 1'b0;
      quiesce("edrop");
      check("edrop_active", 64'(active), 64'd0);
      check("edrop_count", pkt_count, 64'(m_pkts));

      // Randomised masks, credit updates and back-pressure.
      rand_ready = 1'b1;
      for (int r = 0; r < 12; r++) begin
         set_enable(1'b0);
         repeat (2) @(posedge clk);
         #1;
         vc_mask = 4'($urandom_range(1, 15));
         for (int v = 0; v < NVC; v++) begin
            if ($urandom_range(0, 1) == 1) fcp(v, m_fccr[v] + int'($urandom_range(0, 4)) - 1);
         end
         set_enable(1'b1);
         run_model(1000);
         quiesce("rand_round");
         check("rand_count", pkt_count, 64'(m_pkts));
      end

      // Single VC, credit raised one packet at a time across the fccr wrap.
      set_enable(1'b0);
      repeat (2) @(posedge clk);
      #1;
      vc_mask = 4'b0010;
      set_enable(1'b1);
      run_model(1000);
      quiesce("wrap_pre");
      fcp(1, m_fccr[1]);
      base = int'(pkt_count);
      for (int i = 0; i < 40; i++) begin
         fcp(1, m_fccl[1] + 1);
         run_model(1000);
         quiesce("wrap_pkt");
      end
      check("wrap_count", pkt_count - 64'(base), 64'd40);
      fcp(1, m_fccr[1] - 1);
      run_model(1000);
      repeat (30) @(posedge clk);
      #1;
      check("blocked_tvalid", 64'(tvalid), 64'd0);
      check("blocked_count", pkt_count - 64'(base), 64'd40);

      // Asynchronous reset during beat 3.
      rand_ready = 1'b0;
      set_enable(1'b0);
      repeat (2) @(posedge clk);
      #1;
      vc_mask = 4'hF;
      fcp(0, m_fccr[0] + 3);
      set_enable(1'b1);
      start = beats_acc;
      run_model(1);
      cyc = 0;
      while (beats_acc < start + 3 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rst_mid_wait", 64'(beats_acc >= start + 3), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_tvalid", 64'(tvalid), 64'd0);
      check("mid_tlast", 64'(tlast), 64'd0);
      check("mid_tkeep", 64'(tkeep), 64'd0);
      check("mid_tdata", tdata, 64'd0);
      check("mid_count", pkt_count, 64'd0);
      check("mid_active", 64'(active), 64'd0);
      exp_q.delete();
      model_reset();
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      vc_mask = 4'hF;
      enable  = 1'b1;
      run_model(1000);
      quiesce("post_reset");
      check("post_reset_count", pkt_count, 64'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
